// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared switch types: flit type codes, arbiter states, port count default
package sw_pkg;

  // Default number of input ports competing for one output
  localparam int NPORT_DEF = 5;

  // Flit type field encodings, identical to the switch header codes
  typedef enum logic [1:0] {
    BODY = 2'b00,
    HEAD = 2'b01,
    TAIL = 2'b10
  } flit_t;

  // Output arbiter states
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/sw_rr_pick.sv
// rtl/sw_rr_pick.sv - combinational round-robin picker, search starts just after ptr
module sw_rr_pick #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int            c;
  logic [IW-1:0] ci;

  // Walk candidates farthest-first so the nearest requester after ptr wins last
  always_comb begin
    gnt = '0;
    idx = '0;
    any = |req;
    c   = 0;
    ci  = '0;
    for (int k = N; k >= 1; k--) begin
      c  = (int'(ptr) + k) % N;
      ci = IW'(c);
      if (req[ci]) begin
        gnt     = '0;
        gnt[ci] = 1'b1;
        idx     = ci;
      end
    end
  end

endmodule

// File: rtl/sw_oarb.sv
// rtl/sw_oarb.sv - per-output-port arbiter and flit mux; optional SW_OARB_WATCHDOG_EN stall watchdog
module sw_oarb
  import sw_pkg::*;
#(
  parameter int NPORT = NPORT_DEF,
  parameter int DW    = 32,
  parameter int TMO   = 255,
  parameter int IW    = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NPORT-1:0]    req,
  output logic [NPORT-1:0]    ack,
  input  logic [NPORT-1:0]    vin,
  input  logic [2*NPORT-1:0]  tin,
  input  logic [DW*NPORT-1:0] din,
  output logic                vout,
  output logic [1:0]          tout,
  output logic [DW-1:0]       dout,
  output logic [IW-1:0]       owner
);

  arb_state_t       state;
  logic [IW-1:0]    ptr;
  logic [NPORT-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             own_v;
  logic             own_req;
  logic [1:0]       own_t;
  logic [DW-1:0]    own_d;
  logic             wd_fire;
  logic             rel;

  sw_rr_pick #(.N(NPORT), .IW(IW)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Select the current owner's request and flit lane
  always_comb begin
    own_v   = vin[owner];
    own_req = req[owner];
    own_t   = tin[2*int'(owner) +: 2];
    own_d   = din[DW*int'(owner) +: DW];
  end

`ifdef SW_OARB_WATCHDOG_EN
  localparam int CW = (TMO > 255) ? $clog2(TMO + 1) : 8;
  logic [CW-1:0] wcnt;

  // Fire on the stall cycle that brings the count up to TMO
  assign wd_fire = (state == BUSY) && !own_v && (wcnt == CW'(TMO - 1));

  // Count consecutive owner-idle cycles while locked; saturates at TMO
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= '0;
    end else if (state == IDLE || own_v) begin
      wcnt <= '0;
    end else if (wcnt != CW'(TMO)) begin
      wcnt <= wcnt + 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  // Owner lets go on its TAIL flit, on dropping req, or on a watchdog timeout
  assign rel = !own_req || (own_v && (own_t == TAIL)) || wd_fire;

  // Arbiter FSM with registered grant and registered flit output
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ack   <= '0;
      vout  <= 1'b0;
      tout  <= '0;
      dout  <= '0;
      owner <= '0;
      ptr   <= IW'(NPORT - 1);
    end else begin
      case (state)
        IDLE: begin
          vout <= 1'b0;
          if (pick_any) begin
            state <= BUSY;
            owner <= pick_idx;
            ack   <= pick_gnt;
          end
        end
        BUSY: begin
          vout <= own_v;
          tout <= own_t;
          dout <= own_d;
          if (rel) begin
            state <= IDLE;
            ack   <= '0;
            ptr   <= owner;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_oarb.sv
// tb/tb_sw_oarb.sv - scoreboard bench for sw_oarb: grant order, flit forwarding, abort, reset
module tb_sw_oarb;
  import sw_pkg::*;

  localparam int NPORT = 5;
  localparam int DW    = 32;
  localparam int IW    = 3;
  localparam int TMO   = 255;

  logic                clk = 1'b0;
  logic                rst;
  logic [NPORT-1:0]    req;
  logic [NPORT-1:0]    ack;
  logic [NPORT-1:0]    vin;
  logic [2*NPORT-1:0]  tin;
  logic [DW*NPORT-1:0] din;
  logic                vout;
  logic [1:0]          tout;
  logic [DW-1:0]       dout;
  logic [IW-1:0]       owner;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int drop_cyc = 0;
  bit chk_gap = 1'b0;
  bit armed = 1'b0;
  logic [NPORT-1:0] prev_ack = '0;
  logic [DW+1:0] exp_q[$];
  int gnt_q[$];

  sw_oarb #(.NPORT(NPORT), .DW(DW), .TMO(TMO)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .ack   (ack),
    .vin   (vin),
    .tin   (tin),
    .din   (din),
    .vout  (vout),
    .tout  (tout),
    .dout  (dout),
    .owner (owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp_v);
    end
  endtask

  // Monitor: pop and compare flits and grants as the DUT presents them
  always @(negedge clk) begin
    logic [DW+1:0] ef;
    int eg;
    cyc++;
    check("ack_onehot0", 64'($onehot0(ack)), 64'd1);
    if (vout) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_flit: got %0h expected none", {tout, dout});
      end else begin
        ef = exp_q.pop_front();
        check("flit", 64'({tout, dout}), 64'(ef));
      end
    end
    if (ack != 0 && prev_ack == 0) begin
      if (gnt_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_grant: got %0h expected none", ack);
      end else begin
        eg = gnt_q.pop_front();
        check("grant_ack", 64'(ack), 64'(1) << eg);
        check("grant_owner", 64'(owner), 64'(eg));
      end
      if (chk_gap && armed) check("idle_gap", 64'(cyc - drop_cyc), 64'd1);
      armed = 1'b0;
    end
    if (ack == 0 && prev_ack != 0) begin
      drop_cyc = cyc;
      armed = chk_gap;
    end
    prev_ack = ack;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for any grant and return its index
  task automatic wait_any(output int p);
    int w = 0;
    p = 0;
    while (ack == 0 && w < 50) begin tick(); w++; end
    if (ack == 0) begin
      checks++; errors++;
      $display("FAIL wait_any: got no grant expected a grant");
    end
    for (int i = 0; i < NPORT; i++) if (ack[i]) p = i;
  endtask

  // Wait for ack[p], then stream an n-flit packet on input p; returns in the following cycle
  task automatic send_pkt(input int p, input int n, input logic [DW-1:0] base);
    int w = 0;
    logic [1:0] t;
    while (!ack[p] && w < 50) begin tick(); w++; end
    if (!ack[p]) begin
      checks++; errors++;
      $display("FAIL grant_wait: port %0d got ack %0h expected bit set", p, ack);
      return;
    end
    for (int k = 0; k < n; k++) begin
      if (n == 1 || k == n - 1) t = TAIL;
      else if (k == 0) t = HEAD;
      else t = BODY;
      vin[p] = 1'b1;
      tin[2*p +: 2] = t;
      din[DW*p +: DW] = base + DW'(k);
      exp_q.push_back({t, base + DW'(k)});
      tick();
    end
    vin[p] = 1'b0;
  endtask

  task automatic drive_flit(input int p, input logic [1:0] t, input logic [DW-1:0] d);
    vin[p] = 1'b1;
    tin[2*p +: 2] = t;
    din[DW*p +: DW] = d;
    exp_q.push_back({t, d});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, 64'(ack), 64'd0);
    check({tag, "_vout"}, 64'(vout), 64'd0);
    check({tag, "_tout"}, 64'(tout), 64'd0);
    check({tag, "_dout"}, 64'(dout), 64'd0);
    check({tag, "_owner"}, 64'(owner), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1);
  end

  initial begin
    int p;
    int w;
    rst = 1'b1; req = '0; vin = '0; tin = '0; din = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Contention: ptr starts at 4, so order is 0,1,4,0 with one idle cycle between
    chk_gap = 1'b1;
    req = 5'b10011;
    gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(4); gnt_q.push_back(0);
    for (int i = 0; i < 4; i++) begin
      wait_any(p);
      send_pkt(p, 3, 32'h1000 * (i + 1));
      if (i == 3) req = '0;
    end
    chk_gap = 1'b0;
    tick();

    // Single requester: ack one cycle after req, released after TAIL
    req = 5'b00100;
    gnt_q.push_back(2);
    tick();
    check("latency_ack", 64'(ack), 64'b00100);
    send_pkt(2, 3, 32'h20);
    check("tail_release", 64'(ack), 64'd0);
    req = '0;
    tick();

    // Isolation: input 3 streams 0xDEAD while input 1 owns the output
    req = 5'b00010;
    gnt_q.push_back(1); gnt_q.push_back(3);
    tick();
    req[3] = 1'b1;
    vin[3] = 1'b1; tin[7:6] = BODY; din[127:96] = 32'hDEAD;
    send_pkt(1, 4, 32'h100);
    vin[3] = 1'b0; req[1] = 1'b0;
    send_pkt(3, 1, 32'h300);
    req = '0;
    tick();

    // Single-flit packet on input 0
    req = 5'b00001;
    gnt_q.push_back(0);
    send_pkt(0, 1, 32'h1);
    check("single_idle", 64'(ack), 64'd0);
    req = '0;
    tick();

    // Abort: input 2 drops req mid-packet; the abort-cycle flit still goes out
    req = 5'b00100;
    gnt_q.push_back(2);
    tick();
    drive_flit(2, HEAD, 32'h200);
    tick();
    drive_flit(2, BODY, 32'h201);
    tick();
    req = '0;
    drive_flit(2, BODY, 32'h202);
    tick();
    check("abort_ack", 64'(ack), 64'd0);
    vin = '0;
    // ptr is now 2: with inputs 0 and 1 requesting, 0 wins
    req = 5'b00011;
    gnt_q.push_back(0);
    send_pkt(0, 1, 32'h50);
    req = '0;
    tick();

    // Reset mid-packet: outputs clear, ptr returns to 4 so index 0 wins next
    req = 5'b01000;
    gnt_q.push_back(3);
    tick();
    drive_flit(3, HEAD, 32'h3A0);
    tick();
    vin = '0;
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    req = 5'b00011;
    gnt_q.push_back(0);
    send_pkt(0, 2, 32'h60);
    req = '0;
    tick();

`ifdef SW_OARB_WATCHDOG_EN
    // Watchdog: owner 1 stalls; lock held TMO cycles, then pending input 4 is granted
    req = 5'b10010;
    gnt_q.push_back(1); gnt_q.push_back(4);
    tick();
    w = 0;
    while (ack[1] && w < 400) begin tick(); w++; end
    check("wdog_busy_cycles", 64'(w), 64'(TMO));
    req = 5'b10000;
    tick();
    tick();
    req = '0;
    tick();
`endif

    w = 0;
    while ((exp_q.size() != 0 || gnt_q.size() != 0) && w < 20) begin tick(); w++; end
    check("flits_drained", 64'(exp_q.size()), 64'd0);
    check("grants_drained", 64'(gnt_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_oarb.md
Name: sw_oarb

Overview:
- Per-output-port arbiter and flit mux for the packet switch.
- Sits directly downstream of each input-side buffer manager. It receives their one-hot output-port request bits, grants exactly one input at a time with a held ack, and forwards that input's flits to the output link.
- One instance exists per output port. The grant is locked from HEAD through TAIL, so packets never interleave.

Parameters:
- NPORT, 5, number of input ports competing for this output.
- DW, 32, flit payload width excluding the 2-bit type field.
- TMO, 255, watchdog limit in idle cycles while locked (only with SW_OARB_WATCHDOG_EN).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  NPORT  request bit for this output from each input manager
- ack  out  NPORT  one-hot grant back to the input managers
- vin  in  NPORT  flit valid per input (that input's FIFO read enable)
- tin  in  2*NPORT  flit type per input, flattened, input i at [2i+1:2i]
- din  in  DW*NPORT  flit payload per input, flattened, input i at [DW*i+DW-1:DW*i]
- vout  out  1  registered flit valid to output link
- tout  out  2  registered flit type
- dout  out  DW  registered flit payload
- owner  out  clog2(NPORT)  index of the current grantee; valid only while busy

Behaviour:
- Reset values:
  - state IDLE
  - ack=0, vout=0, tout=0, dout=0, owner=0
  - round-robin pointer ptr=NPORT-1, so input 0 has first priority.
- States: IDLE, BUSY.
- IDLE:
  - ack=0.
  - If req!=0, pick the winner by round robin, searching from (ptr+1) mod NPORT upward with wrap.
  - Next cycle: state=BUSY, owner=winner, ack[winner]=1.
  - Latency from req asserted to ack asserted is 1 cycle.
- BUSY:
  - ack is held one-hot at owner, registered, and stable every cycle.
  - Each cycle: vout<=vin[owner]; tout<=tin[owner]; dout<=din[owner]. Data valid-to-output latency is 1 cycle.
  - Flits from non-owners are ignored, even when their vin is asserted.
- Release on TAIL:
  - Trigger: vin[owner]=1 and tin[owner]==`TAIL.
  - The TAIL flit is still forwarded.
  - Next cycle: state=IDLE, ack=0, ptr<=owner.
- Release on abort:
  - Trigger: req[owner]=0 while BUSY.
  - Next cycle: state=IDLE, ack=0, ptr<=owner. Any flit presented in the abort cycle is still forwarded.
- Mandatory idle cycle: at least one IDLE cycle follows every release. No regrant is decided in the TAIL cycle, because the owner's req is still high then.
- Simultaneous requests: the winner is the first set bit at or after (ptr+1) with wrap. The previous owner therefore has lowest priority.
- Single-flit packet (HEAD with no body, type `TAIL):
  - Acts as a release in the first BUSY cycle the flit is valid.
- Flits seen while IDLE are never forwarded; vout=0 in IDLE.
- Type codes (`HEAD, `TAIL, body) come from the shared switch header. No other type code affects state.
- Reset mid-packet: state returns to IDLE on the next edge with all outputs at reset values. The packet is truncated; no recovery is attempted.

Optional Feature:
- Macro: SW_OARB_WATCHDOG_EN.
- Defined:
  - An 8-bit counter (widened to hold TMO) clears on grant and on any vin[owner]=1.
  - It increments each BUSY cycle with vin[owner]=0.
  - When it reaches TMO, the block forces release exactly as on abort: IDLE next cycle, ptr<=owner.
  - The counter saturates and is cleared by rst.
- Undefined: no counter; BUSY is left only via TAIL, abort, or rst.

Decomposition:
- Shared package sw_pkg holds:
  - the flit type enum (HEAD, BODY, TAIL), matching the header macros
  - the arbiter state enum (IDLE, BUSY)
  - the NPORT default constant
- Natural sub-module: sw_rr_pick, a combinational round-robin picker.
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant, index, any.
  - It is reused by the other output instances.

Test Plan:
- Single requester: req=5'b00100 at cycle 0 -> ack=5'b00100 at cycle 1. HEAD/BODY/TAIL on input 2 appear on vout/tout/dout 1 cycle later. ack=0 the cycle after TAIL.
- Contention and fairness: req=5'b10011 held with packets on each input -> grant order 0, 1, 4, 0, with exactly one IDLE cycle between packets and ack never two-hot.
- Isolation: while input 1 owns the output, input 3 drives vin=1 with payload 0xDEAD -> dout never shows 0xDEAD, ack[3]=0 until input 1's TAIL has passed.
- Single-flit packet: input 0 sends one flit with type `TAIL, payload 0x1 -> vout pulses once with tout=`TAIL, dout=0x1, and the block returns to IDLE.
- Abort and reset: input 2 drops req mid-packet -> ack=0 next cycle and ptr=2. Separately, rst asserted mid-packet -> all outputs at reset values next cycle; next grant goes to the lowest requesting index.
- With SW_OARB_WATCHDOG_EN: owner stalls with vin=0 for TMO=255 cycles -> ack drops at cycle 256, and a pending requester is granted after the IDLE cycle.
